// File: rtl/mem_master.sv
// mem_master: load/store initiator driving the data port of the byte-addressed on-chip memory.
// Optional MISALIGNED_SPLIT_EN: misaligned in-range accesses are split into byte accesses.
package mem_master_pkg;
    typedef enum logic [1:0] {BYTE = 2'd0, HALFWORD = 2'd1, WORD = 2'd2} tsize_e;
endpackage

module mem_master
    import mem_master_pkg::*;
#(
    parameter int N  = 1024,
    parameter int AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [31:0]   req_addr,
    input  tsize_e        req_size,
    input  logic          req_unsigned,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_error,
    output logic [AW-1:0] mem_address,
    output tsize_e        mem_tsize,
    output logic          mem_write,
    output logic [31:0]   mem_write_data,
    input  logic [31:0]   mem_data,
    input  logic          mem_rerror,
    input  logic          mem_werror
);

    // state  | meaning
    // IDLE   | waiting for a request, req_ready=1
    // READ   | load on the memory port, result sampled at cycle end
    // WRITE  | store on the memory port, mem_write=1 for this one cycle
    // WCHECK | registered mem_werror is valid only in this cycle
    // RESP   | response held stable until rsp_ready
    // BYTES  | split misaligned access, one byte per cycle
`ifdef MISALIGNED_SPLIT_EN
    typedef enum logic [2:0] {IDLE, READ, WRITE, WCHECK, RESP, BYTES} state_e;
`else
    typedef enum logic [2:0] {IDLE, READ, WRITE, WCHECK, RESP} state_e;
`endif

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    tsize_e        size_q, size_d;
    logic          write_q, write_d;
    logic          unsigned_q, unsigned_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_error_q, rsp_error_d;
`ifdef MISALIGNED_SPLIT_EN
    logic [1:0]    cnt_q, cnt_d;
    logic [31:0]   asm_q, asm_d;
    logic          byte_last;
`endif

    logic [2:0]    req_bytes;
    logic [32:0]   req_end;
    logic          req_oor;
    logic          req_mis;

    function automatic logic [31:0] extend(input logic [31:0] d, input tsize_e sz, input logic uns);
        logic [31:0] r;
        case (sz)
            BYTE:     r = {{24{d[7] & ~uns}}, d[7:0]};
            HALFWORD: r = {{16{d[15] & ~uns}}, d[15:0]};
            default:  r = d;
        endcase
        return r;
    endfunction

    // The range check is done on 33 bits so addresses near 2^32 cannot wrap into range.
    always_comb begin
        case (req_size)
            BYTE: begin
                req_bytes = 3'd1;
                req_mis   = 1'b0;
            end
            HALFWORD: begin
                req_bytes = 3'd2;
                req_mis   = req_addr[0];
            end
            default: begin
                req_bytes = 3'd4;
                req_mis   = |req_addr[1:0];
            end
        endcase
        req_end = {1'b0, req_addr} + 33'(req_bytes);
        req_oor = req_end > 33'(N);
    end

`ifdef MISALIGNED_SPLIT_EN
    assign byte_last = (size_q == HALFWORD) ? (cnt_q == 2'd1) : (cnt_q == 2'd3);
`endif

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        size_d         = size_q;
        write_d        = write_q;
        unsigned_d     = unsigned_q;
        wdata_d        = wdata_q;
        rsp_rdata_d    = rsp_rdata_q;
        rsp_error_d    = rsp_error_q;
`ifdef MISALIGNED_SPLIT_EN
        cnt_d          = cnt_q;
        asm_d          = asm_q;
`endif
        req_ready      = 1'b0;
        rsp_valid      = 1'b0;
        mem_write      = 1'b0;
        mem_address    = addr_q;
        mem_tsize      = size_q;
        mem_write_data = wdata_q;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d      = req_addr[AW-1:0];
                    size_d      = req_size;
                    write_d     = req_write;
                    unsigned_d  = req_unsigned;
                    wdata_d     = req_wdata;
                    rsp_rdata_d = '0;
                    rsp_error_d = 1'b0;
                    if (req_oor) begin
                        state_d     = RESP;
                        rsp_error_d = 1'b1;
                    end
`ifdef MISALIGNED_SPLIT_EN
                    else if (req_mis) begin
                        state_d = BYTES;
                        cnt_d   = '0;
                        asm_d   = '0;
                    end
`else
                    else if (req_mis) begin
                        state_d     = RESP;
                        rsp_error_d = 1'b1;
                    end
`endif
                    else begin
                        state_d = req_write ? WRITE : READ;
                    end
                end
            end
            READ: begin
                rsp_error_d = mem_rerror;
                rsp_rdata_d = mem_rerror ? '0 : extend(mem_data, size_q, unsigned_q);
                state_d     = RESP;
            end
            WRITE: begin
                mem_write = 1'b1;
                state_d   = WCHECK;
            end
            WCHECK: begin
                // OR keeps byte errors accumulated by a split store.
                rsp_error_d = rsp_error_q | mem_werror;
                rsp_rdata_d = '0;
                state_d     = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
`ifdef MISALIGNED_SPLIT_EN
            BYTES: begin
                mem_address    = addr_q + AW'(cnt_q);
                mem_tsize      = BYTE;
                mem_write      = write_q;
                mem_write_data = {24'b0, wdata_q[{cnt_q, 3'b000} +: 8]};
                cnt_d          = cnt_q + 2'd1;
                if (write_q) begin
                    // werror seen here belongs to the byte written on the previous cycle.
                    if (cnt_q != 2'd0) begin
                        rsp_error_d = rsp_error_q | mem_werror;
                    end
                    if (byte_last) begin
                        state_d = WCHECK;
                    end
                end else begin
                    rsp_error_d = rsp_error_q | mem_rerror;
                    asm_d[{cnt_q, 3'b000} +: 8] = mem_data[7:0];
                    if (byte_last) begin
                        state_d     = RESP;
                        rsp_rdata_d = rsp_error_d ? '0 : extend(asm_d, size_q, unsigned_q);
                    end
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            size_q      <= WORD;
            write_q     <= 1'b0;
            unsigned_q  <= 1'b0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
`ifdef MISALIGNED_SPLIT_EN
            cnt_q       <= '0;
            asm_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            write_q     <= write_d;
            unsigned_q  <= unsigned_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_error_q <= rsp_error_d;
`ifdef MISALIGNED_SPLIT_EN
            cnt_q       <= cnt_d;
            asm_q       <= asm_d;
`endif
        end
    end

    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;

endmodule
